// File: rtl/ex_8_7_rtl.sv
// ex_8_7_rtl: sequential shift-and-add unsigned multiplier with Start/Ready handshake.
// Ports: clock, reset_b (async active-low), Start, multiplicand, multiplier (dp_width each),
//        product = {A,Q} (2*dp_width), Ready (high while idle: result valid, Start accepted).
module ex_8_7_rtl #(
    parameter int dp_width = 5
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  Start,
    input  logic [dp_width-1:0]   multiplicand,
    input  logic [dp_width-1:0]   multiplier,
    output logic [2*dp_width-1:0] product,
    output logic                  Ready
);
    localparam int pw = $clog2(dp_width + 1);
    typedef enum logic [1:0] {S_idle, S_add, S_shift} state_t;
    state_t              state;
    logic [dp_width-1:0] A, B, Q;
    logic                C;
    logic [pw-1:0]       P;
    assign product = {A, Q};
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= S_idle;
            Ready <= 1'b1;
            A     <= '0;
            B     <= '0;
            Q     <= '0;
            C     <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                S_idle: if (Start) begin
                    B     <= multiplicand;
                    Q     <= multiplier;
                    A     <= '0;
                    C     <= 1'b0;
                    P     <= pw'(dp_width);
                    Ready <= 1'b0;
                    state <= S_add;
                end
                S_add: begin
                    P <= P - pw'(1);
                    if (Q[0]) {C, A} <= {1'b0, A} + {1'b0, B};
                    state <= S_shift;
                end
                S_shift: begin
                    {C, A, Q} <= {1'b0, C, A, Q[dp_width-1:1]};
                    // P was decremented in the preceding add, so zero here means the last bit is done
                    if (P == '0) begin
                        state <= S_idle;
                        Ready <= 1'b1;
                    end else begin
                        state <= S_add;
                    end
                end
                default: begin
                    state <= S_idle;
                    Ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_8_7_rtl.sv
// tb_ex_8_7_rtl: scoreboard bench for ex_8_7_rtl against an arithmetic product model.
module tb_ex_8_7_rtl;
    localparam int W = 5;
    logic             clock = 1'b0;
    logic             reset_b = 1'b1;
    logic             Start = 1'b0;
    logic [W-1:0]     multiplicand = '0;
    logic [W-1:0]     multiplier = '0;
    logic [2*W-1:0]   product;
    logic             Ready;
    int               checks = 0;
    int               passed = 0;
    int unsigned      q[$];
    bit               prev = 1'b1;
    int               busy = 0;

    ex_8_7_rtl #(.dp_width(W)) dut (
        .clock(clock),
        .reset_b(reset_b),
        .Start(Start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .product(product),
        .Ready(Ready)
    );

    always #5 clock = ~clock;

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: every rising Ready is a result; pop the model value and check it and the latency.
    always @(negedge clock) begin : monitor
        int unsigned e;
        if (!reset_b) begin
            prev = 1'b1;
            busy = 0;
        end else begin
            if (!Ready) busy++;
            else if (!prev) begin
                if (q.size() == 0) chk("unexpected_result", 0, 1);
                else begin
                    e = q.pop_front();
                    chk("product", product, e);
                end
                chk("latency", busy, 2 * W);
                busy = 0;
            end
            prev = Ready;
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            chk("timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_op(int unsigned a, int unsigned b, bit noise);
        multiplicand = W'(a);
        multiplier   = W'(b);
        Start = 1'b1;
        q.push_back(a * b);
        @(negedge clock);
        Start = 1'b0;
        chk("ready_fall", Ready, 0);
        if (noise)
            for (int i = 0; i < 8; i++) begin
                Start = 1'($urandom);
                multiplicand = W'($urandom);
                multiplier = W'($urandom);
                @(negedge clock);
            end
        Start = 1'b0;
        wait_done();
    endtask

    initial begin
        int unsigned corner[5][2] = '{'{0, 0}, '{31, 31}, '{31, 1}, '{1, 31}, '{0, 17}};
        bit seen;
        #3 reset_b = 1'b0;
        #1 chk("reset_product", product, 0);
        chk("reset_ready", Ready, 1);
        @(negedge clock);
        @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 5; i++) do_op(corner[i][0], corner[i][1], 1'b0);
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++) do_op(a, b, 1'b0);
        for (int i = 0; i < 30; i++) do_op($urandom_range(31), $urandom_range(31), 1'b1);
        do_op(13, 11, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("hold_product", product, 143);
            chk("hold_ready", Ready, 1);
        end
        multiplicand = 5;
        multiplier = 6;
        Start = 1'b1;
        q.push_back(30);
        @(negedge clock);
        multiplicand = 7;
        multiplier = 9;
        q.push_back(63);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = Ready;
        end
        chk("b2b_ready_seen", seen, 1);
        @(negedge clock);
        chk("b2b_ready_one_cycle", Ready, 0);
        Start = 1'b0;
        wait_done();
        multiplicand = 31;
        multiplier = 31;
        Start = 1'b1;
        q.push_back(961);
        @(negedge clock);
        Start = 1'b0;
        repeat (4) @(negedge clock);
        @(posedge clock);
        #2 reset_b = 1'b0;
        #1 chk("midop_reset_product", product, 0);
        chk("midop_reset_ready", Ready, 1);
        q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        do_op(21, 3, 1'b0);
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
